// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit.
// Converts the EX/MEM load/store into a request/grant/rvalid data-bus access.
// Stalls the pipeline until the access completes, then returns the
// sign/zero-extended load value toward MEM/WB.
// A watchdog aborts accesses that hang in REQ/RESP (TIMEOUT = 0 disables it).
// Optional build macro: LSU_MISALIGN_TRAP_EN.
//   Defined:   misaligned H/W accesses are flagged on misalign_o and never
//              reach the bus.
//   Undefined: misalign_o is tied low and misaligned accesses are silently
//              forced onto the aligned word/half.
module mem_stage_lsu #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        bus_err_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  done_q;
  logic [TIMEOUT_W-1:0]  wd_cnt_q;
  logic [31:0]           load_data_q;
  logic                  bus_err_q;

  logic                  op;
  logic                  is_load;
  logic                  is_store;
  logic                  is_byte;
  logic                  is_half;
  logic                  is_word;
  logic                  is_unsigned;
  logic                  misalign;
  logic                  active;
  logic                  req;
  logic                  complete;
  logic                  timeout;
  logic [3:0]            be;
  logic [31:0]           wdata_lanes;
  logic [31:0]           load_ext;

  // Operation decode; a simultaneous read and write is treated as a load.
  assign op          = mem_read_i | mem_write_i;
  assign is_load     = mem_read_i;
  assign is_store    = mem_write_i & ~mem_read_i;
  assign is_byte     = (funct3_i[1:0] == 2'b00);
  assign is_half     = (funct3_i[1:0] == 2'b01);
  assign is_word     = ~is_byte & ~is_half;
  assign is_unsigned = funct3_i[2];

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned halves/words are flagged and kept off the bus.
  assign misalign = op & ((is_half & addr_i[0]) |
                          (is_word & (addr_i[1:0] != 2'b00)));
`else
  // No trap: the low address bits below the access size are ignored.
  assign misalign = 1'b0;
`endif

  // An access is wanted while an op is present, not yet finished, and legal.
  assign active = op & ~done_q & ~misalign;

  // Watchdog abort fires on the TIMEOUT-th cycle spent in REQ|RESP, unless
  // the response arrives in that same cycle.
  generate
    if (TIMEOUT != 0) begin : g_watchdog
      assign timeout = (state_q != IDLE) &&
                       (wd_cnt_q == TIMEOUT_W'(TIMEOUT - 1)) &&
                       !((state_q == RESP) && dbus_rvalid_i);
    end else begin : g_no_watchdog
      assign timeout = 1'b0;
    end
  endgenerate

  // Byte-enable generation and store-data lane replication.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    be          = 4'b1111;
    wdata_lanes = wdata_i;
    if (is_byte) begin
      be          = 4'b0001 << addr_i[1:0];
      wdata_lanes = {4{wdata_i[7:0]}};
    end else if (is_half) begin
      be          = addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_lanes = {2{wdata_i[15:0]}};
    end
  end

  // Load extraction: pick the addressed byte/half and extend it.
  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    sel_byte = dbus_rdata_i[7:0];
    sel_half = addr_i[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    load_ext = dbus_rdata_i;
    case (addr_i[1:0])
      2'b00:   sel_byte = dbus_rdata_i[7:0];
      2'b01:   sel_byte = dbus_rdata_i[15:8];
      2'b10:   sel_byte = dbus_rdata_i[23:16];
      default: sel_byte = dbus_rdata_i[31:24];
    endcase
    if (is_byte) begin
      load_ext = is_unsigned ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
    end else if (is_half) begin
      load_ext = is_unsigned ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
    end
  end

  // FSM next-state and request/completion decode.
  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (active) begin
          req     = 1'b1;
          state_d = dbus_gnt_i ? RESP : REQ;
        end
      end
      REQ: begin
        req = 1'b1;
        if (dbus_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (dbus_rvalid_i) begin
          state_d  = IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort: drop the request so no late grant is accepted, return to IDLE.
    if (timeout) begin
      req     = 1'b0;
      state_d = IDLE;
    end
  end

  // State, watchdog counter, completion flag and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      wd_cnt_q    <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      if ((state_q == IDLE) || (state_d == IDLE)) begin
        wd_cnt_q <= '0;
      end else begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      // done_q lives for exactly one cycle: the cycle EX/MEM advances.
      if (done_q) begin
        done_q <= 1'b0;
      end else begin
        done_q <= complete | timeout;
      end
      if (timeout) begin
        load_data_q <= '0;
      end else if (complete && is_load) begin
        load_data_q <= load_ext;
      end
      bus_err_q <= timeout;
    end
  end

  assign dbus_req_o   = req;
  assign dbus_we_o    = is_store;
  assign dbus_addr_o  = {addr_i[31:2], 2'b00};
  assign dbus_be_o    = be;
  assign dbus_wdata_o = wdata_lanes;
  assign stall_o      = active;
  assign load_data_o  = load_data_q;
  assign bus_err_o    = bus_err_q;
  assign misalign_o   = misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: table-driven bus transactions with a load
// result scoreboard, plus hand-written watchdog, reset and alignment cases.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        bus_err_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_load;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gd;
    int          rvd;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_be_o    (dbus_be_o),
    .dbus_wdata_o (dbus_wdata_o),
    .dbus_gnt_i   (dbus_gnt_i),
    .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i (dbus_rdata_i),
    .stall_o      (stall_o),
    .load_data_o  (load_data_o),
    .bus_err_o    (bus_err_o),
    .misalign_o   (misalign_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one op, act as the bus slave, and check it cycle by cycle.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int gd, input int rvd,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic [31:0] e_load,
                        input int e_stall, input logic e_err, input string tag);
    int req_n;
    int stall_n;
    int wait_n;
    int n;
    logic granted;
    logic responded;
    logic [31:0] exp_load;
    req_n = 0; stall_n = 0; wait_n = 0; n = 0;
    granted = 1'b0; responded = 1'b0;
    if (rd) exp_q.push_back(e_load);
    forever begin
      @(negedge clk);
      mem_read_i = rd; mem_write_i = wr; funct3_i = f3;
      addr_i = addr; wdata_i = wdata;
      dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
      #1;
      if (!stall_o) break;
      stall_n++;
      if (dbus_req_o) begin
        check({tag, "_addr"}, dbus_addr_o, e_addr);
        check({tag, "_be"}, {28'b0, dbus_be_o}, {28'b0, e_be});
        check({tag, "_we"}, {31'b0, dbus_we_o}, {31'b0, wr & ~rd});
        if (wr && !rd) check({tag, "_wdata"}, dbus_wdata_o, e_wdata);
        if (req_n == gd) begin
          dbus_gnt_i = 1'b1;
          granted = 1'b1;
        end
        req_n++;
      end else if (granted && !responded) begin
        if (wait_n == rvd) begin
          dbus_rvalid_i = 1'b1;
          dbus_rdata_i = rdata;
          responded = 1'b1;
        end
        wait_n++;
      end
      n++;
      if (n > 40) begin
        checks++; errors++;
        $display("FAIL %s_cycle_bound actual=%0d required<=40", tag, n);
        break;
      end
    end
    // Completion cycle: stall released, request low, result visible.
    check({tag, "_done_req"}, {31'b0, dbus_req_o}, 32'd0);
    check({tag, "_req_cycles"}, req_n, gd + 1);
    check({tag, "_stall_cycles"}, stall_n, e_stall);
    check({tag, "_bus_err"}, {31'b0, bus_err_o}, {31'b0, e_err});
    check({tag, "_misalign"}, {31'b0, misalign_o}, 32'd0);
    if (rd) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s_scoreboard actual=empty required=entry", tag);
      end else begin
        exp_load = exp_q.pop_front();
        check({tag, "_load"}, load_data_o, exp_load);
        model_load = exp_load;
      end
    end else begin
      check({tag, "_load_hold"}, load_data_o, model_load);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=expired required=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // rd wr f3 addr wdata rdata gd rvd e_addr e_be e_wdata e_load
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80AA5511, 0, 0, 32'h100, 4'h8, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80AA5511, 0, 1, 32'h100, 4'h8, 32'h0, 32'h00000080};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80AA5511, 1, 0, 32'h100, 4'hC, 32'h0, 32'h000080AA};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h1234F00D, 0, 0, 32'h100, 4'h3, 32'h0, 32'hFFFFF00D};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h105, 32'h0, 32'h00007F00, 0, 0, 32'h104, 4'h2, 32'h0, 32'h0000007F};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h12345678, 32'h0, 3, 0, 32'h200, 4'h2, 32'h78787878, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'hCAFEBABE, 32'h0, 0, 0, 32'h200, 4'hC, 32'hBABEBABE, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h204, 32'hA5A50F0F, 32'h0, 0, 2, 32'h204, 4'hF, 32'hA5A50F0F, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 3'b111, 32'h108, 32'h0, 32'h89ABCDEF, 0, 0, 32'h108, 4'hF, 32'h0, 32'h89ABCDEF};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h10C, 32'h55AA55AA, 32'h13579BDF, 1, 1, 32'h10C, 4'hF, 32'h0, 32'h13579BDF};
    vecs[11] = '{1'b1, 1'b0, 3'b100, 32'h100, 32'h0, 32'h80AA5511, 0, 0, 32'h100, 4'h1, 32'h0, 32'h00000011};
    vecs[12] = '{1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 32'h7FFF0000, 0, 0, 32'h104, 4'hC, 32'h0, 32'h00007FFF};

    rst_n = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
    addr_i = '0; wdata_i = '0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    model_load = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_req", {31'b0, dbus_req_o}, 32'd0);
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_load", load_data_o, 32'd0);
    check("rst_bus_err", {31'b0, bus_err_o}, 32'd0);
    check("rst_misalign", {31'b0, misalign_o}, 32'd0);

    // Back-to-back table transactions.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, vecs[i].gd, vecs[i].rvd, vecs[i].e_addr, vecs[i].e_be,
             vecs[i].e_wdata, vecs[i].e_load, vecs[i].gd + vecs[i].rvd + 2, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Watchdog: granted load that never gets rvalid.
    run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 0, 1000, 32'h400, 4'hF,
           32'h0, 32'h0, 1 + TO, 1'b1, "wdog");
    @(negedge clk);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    #1;
    check("wdog_err_pulse_end", {31'b0, bus_err_o}, 32'd0);
    @(negedge clk);
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'hFFFFFFFF;
    #1;
    check("stray_rvalid_req", {31'b0, dbus_req_o}, 32'd0);
    @(negedge clk);
    dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    #1;
    check("stray_rvalid_load", load_data_o, 32'd0);
    check("stray_rvalid_stall", {31'b0, stall_o}, 32'd0);

    // Normal load after abort, gives load_data a nonzero value.
    run_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0BADF00D, 0, 0, 32'h500, 4'hF,
           32'h0, 32'h0BADF00D, 2, 1'b0, "post_wdog");

    // Reset while in RESP, then a late rvalid.
    @(negedge clk);
    mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h300;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0;
    #1;
    check("rst_mid_req", {31'b0, dbus_req_o}, 32'd1);
    dbus_gnt_i = 1'b1;
    @(negedge clk);
    dbus_gnt_i = 1'b0; mem_read_i = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h55555555;
    #1;
    check("rst_mid_req_after", {31'b0, dbus_req_o}, 32'd0);
    check("rst_mid_stall", {31'b0, stall_o}, 32'd0);
    check("rst_mid_load", load_data_o, 32'd0);
    check("rst_mid_bus_err", {31'b0, bus_err_o}, 32'd0);
    @(negedge clk);
    dbus_rvalid_i = 1'b0; dbus_rdata_i = '0;
    #1;
    check("rst_mid_rvalid_ignored", load_data_o, 32'd0);
    model_load = '0;
    run_op(1'b1, 1'b0, 3'b000, 32'h302, 32'h0, 32'h00C30000, 0, 0, 32'h300, 4'h4,
           32'h0, 32'hFFFFFFC3, 2, 1'b0, "post_rst");

    // Misaligned accesses.
`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h102;
    #1;
    check("mis_lw_flag", {31'b0, misalign_o}, 32'd1);
    check("mis_lw_req", {31'b0, dbus_req_o}, 32'd0);
    check("mis_lw_stall", {31'b0, stall_o}, 32'd0);
    @(negedge clk);
    funct3_i = 3'b001; addr_i = 32'h101;
    #1;
    check("mis_lh_flag", {31'b0, misalign_o}, 32'd1);
    check("mis_lh_req", {31'b0, dbus_req_o}, 32'd0);
    @(negedge clk);
    mem_read_i = 1'b0;
    #1;
    check("mis_idle_flag", {31'b0, misalign_o}, 32'd0);
    check("mis_load_hold", load_data_o, model_load);
`else
    run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h01234567, 0, 0, 32'h100, 4'hF,
           32'h0, 32'h01234567, 2, 1'b0, "mis_lw_forced");
    run_op(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'hBEEF0000, 0, 0, 32'h100, 4'hC,
           32'h0, 32'hFFFFBEEF, 2, 1'b0, "mis_lh_forced");
`endif

    @(negedge clk);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    #1;
    check("final_stall", {31'b0, stall_o}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
